parking_pass_entry: RTL and testbench



---
 rtl/parking_pass_entry.sv | 204 ++++++++++++++++++++
 tb/tb_parking_pass_entry.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_pass_entry.sv
// Keypad front end for the parking gate: debounced ENTER/CLEAR, two-digit code capture, timed code hold.
// Define PARKING_ENTRY_HEX_EN to add the HEX_ENTRY seven-segment output.
module parking_pass_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000,
  parameter int unsigned HOLD_CYCLES     = 16
) (
  input  logic       clock_in,
  input  logic       rst_in,
  input  logic       car_present,
  input  logic [1:0] key_in,
  input  logic       key_enter,
  input  logic       key_clear,
  output logic [1:0] pass_1,
  output logic [1:0] pass_2,
  output logic       pass_valid,
  output logic       entry_busy
`ifdef PARKING_ENTRY_HEX_EN
  ,
  output logic [6:0] HEX_ENTRY
`endif
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DIGIT1, DIGIT2, HOLD} state_t;

  // Button index 0 is ENTER, index 1 is CLEAR.
  logic [1:0]            btn_raw;
  logic [1:0]            btn_sync1;
  logic [1:0]            btn_sync2;
  logic [1:0]            btn_deb;
  logic [1:0]            btn_pulse;
  logic [1:0][CNT_W-1:0] db_cnt;
  logic                  enter_p;
  logic                  clear_p;

  assign btn_raw = {key_clear, key_enter};
  assign enter_p = btn_pulse[0];
  assign clear_p = btn_pulse[1];

  // Two-flop synchronizer for the raw push-buttons.
  always_ff @(posedge clock_in or negedge rst_in) begin
    if (!rst_in) begin
      btn_sync1 <= '0;
      btn_sync2 <= '0;
    end else begin
      btn_sync1 <= btn_raw;
      btn_sync2 <= btn_sync1;
    end
  end

  // Debounce: the level flips only after the synchronized input has disagreed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clock_in or negedge rst_in) begin
    if (!rst_in) begin
      btn_deb   <= '0;
      btn_pulse <= '0;
      db_cnt    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        btn_pulse[i] <= 1'b0;
        if (btn_sync2[i] == btn_deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] >= DB_LAST) begin
          btn_deb[i]   <= btn_sync2[i];
          btn_pulse[i] <= btn_sync2[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  state_t           state_q, state_d;
  logic [1:0]       d1_q, d1_d;
  logic [1:0]       d2_q, d2_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [1:0]       pass_1_d, pass_2_d;
  logic             pass_valid_d;
  logic             entry_busy_d;

`ifdef PARKING_ENTRY_HEX_EN
  logic [6:0] hex_d;

  function automatic logic [6:0] seg_digit(input logic [1:0] d);
    case (d)
      2'd0:    seg_digit = 7'b1000000;
      2'd1:    seg_digit = 7'b1111001;
      2'd2:    seg_digit = 7'b0100100;
      default: seg_digit = 7'b0110000;
    endcase
  endfunction
`endif

  // State and output registers.
  always_ff @(posedge clock_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      d1_q       <= '0;
      d2_q       <= '0;
      tmo_q      <= '0;
      hold_q     <= '0;
      pass_1     <= '0;
      pass_2     <= '0;
      pass_valid <= 1'b0;
      entry_busy <= 1'b0;
`ifdef PARKING_ENTRY_HEX_EN
      HEX_ENTRY  <= 7'b1111111;
`endif
    end else begin
      state_q    <= state_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      tmo_q      <= tmo_d;
      hold_q     <= hold_d;
      pass_1     <= pass_1_d;
      pass_2     <= pass_2_d;
      pass_valid <= pass_valid_d;
      entry_busy <= entry_busy_d;
`ifdef PARKING_ENTRY_HEX_EN
      HEX_ENTRY  <= hex_d;
`endif
    end
  end

  // Next state and next register values; clear beats enter, enter beats timeout.
  always_comb begin
    state_d      = state_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    tmo_d        = tmo_q;
    hold_d       = hold_q;
    pass_1_d     = pass_1;
    pass_2_d     = pass_2;
    pass_valid_d = pass_valid;

    unique case (state_q)
      IDLE: begin
        tmo_d  = '0;
        hold_d = '0;
        if (car_present) state_d = DIGIT1;
      end
      DIGIT1, DIGIT2: begin
        if (clear_p) begin
          state_d = DIGIT1;
          d1_d    = '0;
          d2_d    = '0;
          tmo_d   = '0;
        end else if (enter_p) begin
          tmo_d = '0;
          if (state_q == DIGIT1) begin
            d1_d    = key_in;
            state_d = DIGIT2;
          end else begin
            d2_d         = key_in;
            state_d      = HOLD;
            hold_d       = '0;
            pass_1_d     = d1_q;
            pass_2_d     = key_in;
            pass_valid_d = 1'b1;
          end
        end else if (tmo_q >= TMO_LAST) begin
          state_d = IDLE;
          d1_d    = '0;
          d2_d    = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (hold_q >= HOLD_LAST) begin
          state_d      = car_present ? DIGIT1 : IDLE;
          hold_d       = '0;
          tmo_d        = '0;
          pass_1_d     = '0;
          pass_2_d     = '0;
          pass_valid_d = 1'b0;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    entry_busy_d = (state_d == DIGIT1) || (state_d == DIGIT2);

`ifdef PARKING_ENTRY_HEX_EN
    hex_d = 7'b1111111;
    case (state_d)
      DIGIT1:  hex_d = 7'b0111111;
      DIGIT2:  hex_d = seg_digit(d1_d);
      HOLD:    hex_d = seg_digit(d2_d);
      default: hex_d = 7'b1111111;
    endcase
`endif
  end

endmodule

// File: tb/tb_parking_pass_entry.sv
// Scoreboard bench for parking_pass_entry: random keypad sessions against an abstract digit-entry model.
module tb_parking_pass_entry;

  localparam int unsigned DB   = 4;
  localparam int unsigned TMO  = 50;
  localparam int unsigned HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       car_present = 1'b0;
  logic [1:0] key_in = 2'b00;
  logic       key_enter = 1'b0;
  logic       key_clear = 1'b0;
  logic [1:0] pass_1;
  logic [1:0] pass_2;
  logic       pass_valid;
  logic       entry_busy;
`ifdef PARKING_ENTRY_HEX_EN
  logic [6:0] hex_entry;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Expected codes {first, second}, in completion order.
  logic [3:0] exp_q[$];
  int         ndig = 0;
  logic [1:0] d1m = 2'b00;

  always #5 clk = ~clk;

  parking_pass_entry #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TMO),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clock_in   (clk),
    .rst_in     (rst_n),
    .car_present(car_present),
    .key_in     (key_in),
    .key_enter  (key_enter),
    .key_clear  (key_clear),
    .pass_1     (pass_1),
    .pass_2     (pass_2),
    .pass_valid (pass_valid),
`ifdef PARKING_ENTRY_HEX_EN
    .entry_busy (entry_busy),
    .HEX_ENTRY  (hex_entry)
`else
    .entry_busy (entry_busy)
`endif
  );

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pops an expected code on each pass_valid rise and times the hold window.
  logic       mon_prev = 1'b0;
  int         mon_run = 0;
  logic [3:0] mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev = 1'b0;
      mon_run  = 0;
    end else begin
      if (pass_valid && !mon_prev) begin
        mon_run = 1;
        if (exp_q.size() == 0) begin
          check("unexpected_pass_valid", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pass_1", int'(pass_1), int'(mon_e[3:2]));
          check("pass_2", int'(pass_2), int'(mon_e[1:0]));
        end
      end else if (pass_valid) begin
        mon_run++;
      end else begin
        if (mon_prev) check("hold_len", mon_run, int'(HOLD));
        check("idle_code_zero", int'({pass_1, pass_2}), 0);
      end
      mon_prev = pass_valid;
    end
  end

  task automatic press(input logic [1:0] code, input logic en, input logic cl);
    @(negedge clk);
    key_in    = code;
    key_enter = en;
    key_clear = cl;
    repeat (10) @(negedge clk);
    key_enter = 1'b0;
    key_clear = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic enter_digit(input logic [1:0] code);
    if (ndig == 0) begin
      d1m  = code;
      ndig = 1;
    end else begin
      exp_q.push_back({d1m, code});
      ndig = 0;
    end
    press(code, 1'b1, 1'b0);
  endtask

  task automatic clear_entry(input logic with_enter);
    ndig = 0;
    press(2'($urandom_range(0, 3)), with_enter, 1'b1);
  endtask

  task automatic wait_pv();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (pass_valid) ok = 1'b1;
    end
    if (!ok) check("pass_valid_wait", 0, 1);
  endtask

  // Entry must survive well short of the timeout, be gone after it, and restart with a car.
  task automatic timeout_seq();
    car_present = 1'b0;
    repeat (25) @(negedge clk);
    check("busy_before_timeout", int'(entry_busy), 1);
    repeat (25) @(negedge clk);
    check("busy_after_timeout", int'(entry_busy), 0);
    ndig = 0;
    car_present = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_reentry", int'(entry_busy), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_pass_1", int'(pass_1), 0);
    check("rst_pass_2", int'(pass_2), 0);
    check("rst_pass_valid", int'(pass_valid), 0);
    check("rst_entry_busy", int'(entry_busy), 0);
`ifdef PARKING_ENTRY_HEX_EN
    check("rst_hex", int'(hex_entry), 'h7F);
`endif
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_car", int'(entry_busy), 0);

    // Happy path
    car_present = 1'b1;
    repeat (2) @(negedge clk);
    check("busy_on_car", int'(entry_busy), 1);
    enter_digit(2'b01);
    check("busy_digit2", int'(entry_busy), 1);
    enter_digit(2'b10);
    check("busy_after_hold_car", int'(entry_busy), 1);

    // Bouncing ENTER yields one digit
    @(negedge clk);
    key_in = 2'b11;
    for (int i = 0; i < 5; i++) begin
      key_enter = ((i % 2) == 0);
      @(negedge clk);
    end
    key_enter = 1'b1;
    repeat (10) @(negedge clk);
    key_enter = 1'b0;
    repeat (10) @(negedge clk);
    d1m  = 2'b11;
    ndig = 1;
    check("busy_after_bounce", int'(entry_busy), 1);
    enter_digit(2'b01);

    // Clear wins over simultaneous enter
    enter_digit(2'b10);
    clear_entry(1'b1);
    check("busy_after_clear", int'(entry_busy), 1);
    enter_digit(2'b11);
    enter_digit(2'b00);

    // Timeout after one digit
    enter_digit(2'b01);
    timeout_seq();

    // Random sessions
    for (int k = 0; k < 40; k++) begin
      int r = int'($urandom_range(0, 9));
      if (r < 7) enter_digit(2'($urandom_range(0, 3)));
      else if (r < 9) clear_entry(1'($urandom_range(0, 1)));
      else timeout_seq();
      check("busy_random", int'(entry_busy), 1);
    end

    // Reset during the third HOLD cycle
    if (ndig == 1) enter_digit(2'($urandom_range(0, 3)));
    enter_digit(2'b10);
    exp_q.push_back(4'b1011);
    ndig = 0;
    key_in    = 2'b11;
    key_enter = 1'b1;
    wait_pv();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_pass_valid", int'(pass_valid), 0);
    check("async_rst_pass_1", int'(pass_1), 0);
    check("async_rst_pass_2", int'(pass_2), 0);
    check("async_rst_busy", int'(entry_busy), 0);
    key_enter   = 1'b0;
    car_present = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", int'(entry_busy), 0);
    check("pv_after_rst", int'(pass_valid), 0);

`ifdef PARKING_ENTRY_HEX_EN
    car_present = 1'b1;
    repeat (2) @(negedge clk);
    check("hex_dash", int'(hex_entry), 'h3F);
    enter_digit(2'b10);
    check("hex_d1", int'(hex_entry), 'h24);
    exp_q.push_back(4'b1001);
    ndig = 0;
    key_in    = 2'b01;
    key_enter = 1'b1;
    wait_pv();
    check("hex_d2", int'(hex_entry), 'h79);
    car_present = 1'b0;
    repeat (10) @(negedge clk);
    key_enter = 1'b0;
    repeat (10) @(negedge clk);
    check("hex_off", int'(hex_entry), 'h7F);
    check("hex_idle_busy", int'(entry_busy), 0);
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
